// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit
//   Instruction supply stage for the multicycle execute core. A small
//   loadable instruction memory is walked by a program counter, and the
//   words reach the core through a 2-entry prefetch buffer on a
//   valid/ready handshake. The done flag marks the end of the program,
//   so the core does not need its own PC/MAX_PC comparison.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   load_en/addr/data       memory write port; honoured only in IDLE/DONE
//   max_pc                  program length in words, sampled on start
//   start                   begin a run from address 0 (IDLE/DONE only)
//   ins_valid/data/pc       buffer head towards the core
//   ins_ready               core accepts the head instruction
//   busy                    run in progress (FETCH or DRAIN)
//   done                    program fully delivered (DONE)
module ins_fetch_unit #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int IW    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [IW-1:0]   load_data,
  input  logic [AW:0]     max_pc,
  input  logic            start,
  output logic            ins_valid,
  output logic [IW-1:0]   ins_data,
  output logic [AW-1:0]   ins_pc,
  input  logic            ins_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t          state, state_nxt;
  logic [IW-1:0]   mem [DEPTH];
  logic [AW:0]     pc, len, pc_nxt, len_start;
  logic [1:0]      count, count_nxt;
  logic [IW-1:0]   buf_data [2];
  logic [AW-1:0]   buf_pc   [2];
  logic            idle_like, pop, push, wr_hi;

  // Loads and starts are only honoured while no run is in flight.
  assign idle_like = (state == IDLE) || (state == DONE);

  // Program length is clamped so pc never indexes past the memory.
  assign len_start = (max_pc > DEPTH_W) ? DEPTH_W : max_pc;

  assign pop  = ins_valid && ins_ready;
  // A full buffer may still accept a word when the head leaves this cycle.
  assign push = (state == FETCH) && (pc < len) && ((count < 2'd2) || pop);

  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign pc_nxt    = pc + (AW+1)'(push);

  // Tail slot for the incoming word, measured after the head has left.
  assign wr_hi = (count == 2'd2) || ((count == 2'd1) && !pop);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (len_start == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (pc_nxt == len) state_nxt = (count_nxt == 2'd0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (count_nxt == 2'd0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      count       <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (idle_like && start) begin
        pc  <= '0;
        len <= len_start;
      end else begin
        pc <= pc_nxt;
      end
      // Head shifts forward on pop; a push in the same cycle lands in the
      // slot freed behind it (the later assignment wins for slot 0).
      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_pc[0]   <= buf_pc[1];
      end
      if (push) begin
        if (wr_hi) begin
          buf_data[1] <= mem[pc[AW-1:0]];
          buf_pc[1]   <= pc[AW-1:0];
        end else begin
          buf_data[0] <= mem[pc[AW-1:0]];
          buf_pc[0]   <= pc[AW-1:0];
        end
      end
    end
  end

  // NOTE: the instruction memory has no reset; the program must survive
  // rst_n, and a reset would also turn the array into plain flops.
  always_ff @(posedge clk) begin
    if (load_en && idle_like) mem[load_addr] <= load_data;
  end

  assign ins_valid = (count != 2'd0);
  assign ins_data  = buf_data[0];
  assign ins_pc    = buf_pc[0];
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);

endmodule
